// File: rtl/step_move_sequencer.sv
// Step/direction move sequencer: accepts one move command at a time and
// emits a clamped-rate train of step strobes while tracking position.
module step_move_sequencer #(
    parameter int unsigned MIN_PERIOD = 1000,
    parameter int unsigned DIR_SETUP  = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_dir,
    input  logic [15:0] cmd_steps,
    input  logic [23:0] cmd_period,
    input  logic        abort,
    output logic        direction,
    output logic        en,
    output logic        step_pulse,
    output logic        busy,
    output logic        done,
    output logic [15:0] position
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN,
        DONE
    } state_t;

    localparam logic [23:0] MIN_P      = 24'(MIN_PERIOD);
    localparam logic [23:0] SETUP_LAST = 24'(DIR_SETUP - 1);

    state_t      state_q, state_d;
    logic        dir_q, dir_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] pos_q, pos_d;
    logic [23:0] per_q, per_d;
    logic [23:0] cnt_q, cnt_d;
    logic        step;

    // State register; direction resets forward, everything else to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= 1'b1;
            rem_q   <= '0;
            pos_q   <= '0;
            per_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            pos_q   <= pos_d;
            per_q   <= per_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; cnt_q serves as setup timer and period counter.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        pos_d   = pos_q;
        per_d   = per_q;
        cnt_d   = cnt_q;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    per_d = (cmd_period < MIN_P) ? MIN_P : cmd_period;
                    rem_d = cmd_steps;
                    cnt_d = '0;
                    if (cmd_steps == 16'd0) begin
                        state_d = DONE;
                    end else if (cmd_dir != dir_q) begin
                        dir_d   = cmd_dir;
                        state_d = SETUP;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            SETUP: begin
                if (abort) begin
                    state_d = DONE;
                end else if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = DONE;
                end else if (cnt_q == per_q - 24'd1) begin
                    step  = 1'b1;
                    cnt_d = '0;
                    rem_d = rem_q - 16'd1;
                    pos_d = dir_q ? pos_q + 16'd1 : pos_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready  = (state_q == IDLE);
    assign en         = (state_q == RUN);
    assign busy       = (state_q == SETUP) || (state_q == RUN);
    assign done       = (state_q == DONE);
    assign step_pulse = step;
    assign direction  = dir_q;
    assign position   = pos_q;

endmodule

// File: tb/tb_step_move_sequencer.sv
// Randomized bench for step_move_sequencer with a timeline-based model
// of pulse instants, setup delay and position.
module tb_step_move_sequencer;

    localparam int MINP = 1000;
    localparam int DS   = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [15:0] cmd_steps;
    logic [23:0] cmd_period;
    logic        abort;
    logic        direction;
    logic        en;
    logic        step_pulse;
    logic        busy;
    logic        done;
    logic [15:0] position;

    int n_chk  = 0;
    int n_fail = 0;

    logic        m_dir;
    logic [15:0] m_pos;

    step_move_sequencer #(.MIN_PERIOD(MINP), .DIR_SETUP(DS)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .direction  (direction),
        .en         (en),
        .step_pulse (step_pulse),
        .busy       (busy),
        .done       (done),
        .position   (position)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // {step_pulse, en, busy, done, cmd_ready}
    function automatic logic [4:0] outs();
        return {step_pulse, en, busy, done, cmd_ready};
    endfunction

    // One move: model derives pulse k at cycle su + k*p - 1 after accept.
    task automatic do_move(input logic d, input int n, input int per,
                           input int ab);
        int p, su, t, r, k;
        bit fin, pul;
        p  = (per < MINP) ? MINP : per;
        su = (n > 0 && d != m_dir) ? DS : 0;
        @(negedge clk);
        check("ready", 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_dir    = d;
        cmd_steps  = 16'(n);
        cmd_period = 24'(per);
        abort      = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        abort      = 1'b0;
        cmd_valid  = 1'($urandom_range(0, 1));
        cmd_dir    = ~d;
        cmd_steps  = 16'($urandom);
        cmd_period = 24'($urandom);
        if (n > 0) m_dir = d;
        fin = (n == 0);
        t   = 0;
        while (!fin) begin
            pul = 1'b0;
            k   = 0;
            if (t >= su) begin
                r = t - su + 1;
                if (r % p == 0) k = r / p;
            end
            if (k != 0 && k == ab) begin
                abort = 1'b1;
                fin   = 1'b1;
            end else if (k != 0) begin
                pul = 1'b1;
                if (k == n) fin = 1'b1;
            end
            @(negedge clk);
            check("cycle", 32'(outs()),
                  32'({pul, (t >= su), 1'b1, 1'b0, 1'b0}));
            check("pos_run", 32'(position), 32'(m_pos));
            if (pul) m_pos = d ? m_pos + 16'd1 : m_pos - 16'd1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            t++;
        end
        abort     = 1'($urandom_range(0, 1));
        cmd_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("done_cyc", 32'(outs()), 32'b00010);
        check("done_pos", 32'(position), 32'(m_pos));
        check("done_dir", 32'(direction), 32'(m_dir));
        @(posedge clk);
        #1;
        abort     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("idle", 32'(outs()), 32'b00001);
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_steps  = '0;
        cmd_period = '0;
        abort      = 1'b0;
        m_dir      = 1'b1;
        m_pos      = '0;
        #1;
        check("rst_outs", 32'(outs()), 32'b00001);
        check("rst_dir", 32'(direction), 32'd1);
        check("rst_pos", 32'(position), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        do_move(1'b1, 3, 2000, 0);
        check("pos_3", 32'(position), 32'h3);
        do_move(1'b0, 2, 10, 0);
        check("pos_1", 32'(position), 32'h1);
        do_move(1'b0, 1, 0, 0);
        do_move(1'b0, 1, 1200, 0);
        check("pos_ffff", 32'(position), 32'hffff);
        do_move(1'b1, 1, 1000, 0);
        check("pos_0", 32'(position), 32'h0);
        do_move(1'b0, 0, 500, 0);
        check("zero_dir", 32'(direction), 32'd1);
        do_move(1'b1, 100, 1000, 5);
        check("abort_pos", 32'(position), 32'h4);

        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_dir    = 1'b1;
        cmd_steps  = 16'd5;
        cmd_period = 24'd1000;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (2500) @(posedge clk);
        @(negedge clk);
        check("pre_rst_pos", 32'(position), 32'(m_pos + 16'd2));
        rst = 1'b1;
        #1;
        check("rst_mid", 32'(outs()), 32'b00001);
        check("rst_mid_pos", 32'(position), 32'd0);
        check("rst_mid_dir", 32'(direction), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("rst_hold", 32'(outs()), 32'b00001);
        end
        rst   = 1'b0;
        m_pos = '0;
        m_dir = 1'b1;
        do_move(1'b1, 2, 1100, 0);
        check("post_rst_pos", 32'(position), 32'h2);

        for (int i = 0; i < 8; i++) begin
            int n, per, ab;
            n   = $urandom_range(0, 3);
            per = $urandom_range(0, 2500);
            ab  = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
            do_move(1'($urandom_range(0, 1)), n, per, ab);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/step_move_sequencer.md
STEP_MOVE_SEQUENCER -- requirements
Module: step_move_sequencer

Interface
REQ-001 SHALL have parameter MIN_PERIOD, 1000, minimum clk cycles between step pulses; smaller commanded periods are clamped to this value.
REQ-002 SHALL have parameter DIR_SETUP, 50, clk cycles en is held low after a direction change before the first step.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  move command present.
REQ-006 SHALL have port cmd_ready  output  1  sequencer can accept a command.
REQ-007 SHALL have port cmd_dir  input  1  requested direction (1 = forward, position increments).
REQ-008 SHALL have port cmd_steps  input  16  unsigned number of steps to issue.
REQ-009 SHALL have port cmd_period  input  24  unsigned clk cycles per step.
REQ-010 SHALL have port abort  input  1  terminate the current move.
REQ-011 SHALL have port direction  output  1  direction to the step driver.
REQ-012 SHALL have port en  output  1  enable to the step driver.
REQ-013 SHALL have port step_pulse  output  1  one-cycle strobe per issued step.
REQ-014 SHALL have port busy  output  1  move in progress (SETUP or RUN).
REQ-015 SHALL have port done  output  1  one-cycle strobe at move end.
REQ-016 SHALL have port position  output  16  two's-complement step position.

Function
REQ-017 SHALL implement states IDLE, SETUP, RUN, DONE; cmd_ready = 1 only in IDLE.
REQ-018 SHALL accept a command on a rising edge with cmd_valid=1 and cmd_ready=1, latching cmd_dir, cmd_steps, and period = max(cmd_period, MIN_PERIOD).
REQ-019 SHALL ignore cmd_valid while not in IDLE; no queuing.
REQ-020 SHALL, on accepting cmd_steps=0, go IDLE->DONE with no step_pulse and no change to direction.
REQ-021 SHALL, on accepting with cmd_steps>0 and cmd_dir different from direction, update direction on the accept edge and enter SETUP.
REQ-022 SHALL, on accepting with cmd_steps>0 and cmd_dir equal to direction, enter RUN directly.
REQ-023 SHALL remain in SETUP for exactly DIR_SETUP cycles with en=0, then enter RUN.
REQ-024 SHALL drive en=1 only in RUN; direction holds its value in all other states.
REQ-025 SHALL, in RUN, run a period counter from 0; when it equals period-1, assert step_pulse for that cycle and restart the counter at 0, so step k (k=1..N) occurs k*period cycles after RUN entry.
REQ-026 SHALL, with each step_pulse, decrement the remaining count and add +1 (direction=1) or -1 (direction=0) to position, wrapping modulo 2^16 (0x7FFF+1 = 0x8000, 0x0000-1 = 0xFFFF).
REQ-027 SHALL enter DONE on the edge after the step_pulse that brings remaining to 0.
REQ-028 SHALL, on abort=1 in SETUP or RUN, enter DONE on the next edge; if abort coincides with a step-pulse cycle, abort wins: no step_pulse, position unchanged.
REQ-029 SHALL ignore abort in IDLE and DONE.
REQ-030 SHALL assert done=1 for exactly the single DONE cycle, then return to IDLE.
REQ-031 SHALL assert busy=1 in SETUP and RUN only.

Reset
REQ-032 SHALL, on rst=1, asynchronously force state=IDLE, cmd_ready=1 (combinational from IDLE), direction=1, en=0, step_pulse=0, busy=0, done=0, position=0, counters=0.
REQ-033 SHALL, on rst asserted mid-move, discard the move with no done pulse and no further steps.
REQ-034 SHALL resume normal operation on the first rising edge after rst deasserts.

Verification
REQ-035 After reset, dir=1, steps=3, period=2000 -> no SETUP; step_pulse at 2000, 4000, 6000 cycles after accept; done one cycle later; position=3.
REQ-036 After REQ-035, dir=0, steps=2, period=10 -> period clamped to 1000; en low 50 cycles; pulses at 1000 and 2000 cycles after RUN entry; position=1.
REQ-037 position=0, dir=0, steps=1 -> position=0xFFFF; then dir=1, steps=1 -> position=0x0000.
REQ-038 steps=0 -> done pulse, no step_pulse, en never 1, direction unchanged.
REQ-039 steps=100, period=1000; abort on the cycle of the 5th step -> exactly 4 pulses, position +4, done next cycle; cmd_valid during the move is ignored.
REQ-040 rst asserted mid-RUN -> outputs immediately at reset values, no done pulse; a new command after release executes normally.
